// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock programmable FIFO family.
//   DSIZE_DEF / ASIZE_DEF : default data and address widths
//   FWFT_STD / FWFT_ON    : read-mode encodings for the FWFT parameter
//   depth_of()            : entry count for a given address width
package fifo_pkg;

    localparam int unsigned DSIZE_DEF = 32;
    localparam int unsigned ASIZE_DEF = 6;

    localparam int unsigned FWFT_STD  = 0;
    localparam int unsigned FWFT_ON   = 1;

    function automatic int unsigned depth_of(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_prog: DEPTH x DSIZE, synchronous write,
// combinational read, no reset on the array.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write word
//   i_raddr : read address
//   o_rdata : word at i_raddr (combinational)
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int unsigned DEPTH = depth_of(ASIZE);

    logic [DSIZE-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, synchronous clear, sticky overflow/underflow and a
// selectable standard / first-word-fall-through read mode.
//   clk, rst (async, active-low), clear (sync flush)
//   write_data / write_enable, read_enable
//   almost_full_thresh / almost_empty_thresh : quasi-static thresholds
//   read_data / read_valid                   : read port
//   full, empty, almost_full, almost_empty, count : status from pointers
//   overflow, underflow                      : sticky error flags
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEF,
    parameter int unsigned ASIZE = ASIZE_DEF,
    parameter int unsigned FWFT  = FWFT_STD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DSIZE-1:0] write_data,
    input  logic             write_enable,
    input  logic             read_enable,
    input  logic [ASIZE:0]   almost_full_thresh,
    input  logic [ASIZE:0]   almost_empty_thresh,
    output logic [DSIZE-1:0] read_data,
    output logic             read_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = ASIZE + 1;

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic             r_overflow;
    logic             r_underflow;
    logic [PW-1:0]    w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [DSIZE-1:0] w_mem_rdata;

    // Status decode from registered pointers only
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                     (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);

    // A write into a full FIFO is allowed when a read frees a slot in the same cycle
    assign w_rd_ok = read_enable && !w_empty;
    assign w_wr_ok = write_enable && (!w_full || w_rd_ok);

    // Pointer and sticky-flag state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (write_enable && w_full && !w_rd_ok) begin
                r_overflow <= 1'b1;
            end
            if (read_enable && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage; clear blocks the write so memory is left as it was
    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok && !clear),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (write_data),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Read port: head word shown directly in FWFT, registered on pop otherwise
    if (FWFT == FWFT_ON) begin : g_fwft
        assign read_data  = w_mem_rdata;
        assign read_valid = !w_empty;
    end else begin : g_std
        logic [DSIZE-1:0] r_read_data;
        logic             r_read_valid;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_read_data  <= '0;
                r_read_valid <= 1'b0;
            end else if (clear) begin
                r_read_valid <= 1'b0;
            end else begin
                r_read_valid <= w_rd_ok;
                if (w_rd_ok) begin
                    r_read_data <= w_mem_rdata;
                end
            end
        end

        assign read_data  = r_read_data;
        assign read_valid = r_read_valid;
    end

    assign count        = w_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (w_count >= almost_full_thresh);
    assign almost_empty = (w_count <= almost_empty_thresh);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO for same-domain buffering between host-controller stages (e.g. AXI slave to packet engine), succeeding the dual-clock FIFO where no clock crossing exists. Adds programmable almost-full/almost-empty thresholds, an occupancy count, synchronous clear, sticky overflow/underflow flags and a selectable first-word-fall-through (FWFT) read mode.

## Interface
- DSIZE, 32, data width in bits
- ASIZE, 6, address width; DEPTH = 2^ASIZE entries
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous flush, active-high
- write_data  input  DSIZE  write word
- write_enable  input  1  write request
- read_enable  input  1  read request (FWFT: pop)
- almost_full_thresh  input  ASIZE+1  almost_full asserted when count >= this
- almost_empty_thresh  input  ASIZE+1  almost_empty asserted when count <= this
- read_data  output  DSIZE  read word
- read_valid  output  1  read_data qualifier
- full, empty  output  1  occupancy flags
- almost_full, almost_empty  output  1  threshold flags
- count  output  ASIZE+1  words stored, 0..DEPTH
- overflow, underflow  output  1  sticky error flags

## Operation
- Pointers write_ptr/read_ptr are ASIZE+1-bit binary; address = low ASIZE bits; MSB is wrap bit.
- empty: pointers equal. full: MSBs differ, low bits equal. count = write_ptr - read_ptr modulo 2^(ASIZE+1).
- Read accepted (rd_ok) = read_enable && !empty. Write accepted (wr_ok) = write_enable && (!full || rd_ok).
- Simultaneous read+write when full: both accepted, count stays DEPTH. When empty: write accepted, read rejected, underflow set.
- overflow set on write_enable && full && !rd_ok; underflow set on read_enable && empty. Both sticky until clear or rst. Rejected ops change no state besides the sticky flag.
- Standard mode: on rd_ok, head word registered into read_data and read_valid=1 next cycle; read_valid=0 otherwise; read_data holds last value.
- FWFT mode: read_data = mem[read addr] combinationally; read_valid = !empty; read_enable pops the shown word.
- clear: next edge resets pointers, count, read_valid, overflow, underflow; overrides write/read in the same cycle; memory contents untouched; read_data holds.
- Threshold inputs are quasi-static; comparisons are unsigned on ASIZE+1 bits. Thresholds > DEPTH make almost_full permanently 0.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=1 only if almost_full_thresh==0, read_valid=0, read_data=0, overflow=0, underflow=0.
- Status flags and count are decoded from registered pointers only; no combinational path from write_enable/read_enable to any flag.
- Write -> empty deasserts / count increments: 1 cycle after the accepting edge.
- Standard read latency: 1 cycle (data and read_valid at the edge after rd_ok). FWFT: first word visible 1 cycle after the write to an empty FIFO.
- Reset asserted mid-operation: all outputs take reset values immediately (asynchronous), regardless of clock.
- Throughput: one write and one read per cycle sustained.

## Structure
- Shared package fifo_pkg: default DSIZE/ASIZE, FWFT mode encodings, DEPTH derivation.
- Sub-module sync_fifo_mem: DEPTH x DSIZE array, synchronous write port, combinational read port; no reset on array.
- Top holds pointers, flag decode, sticky flags and standard-mode output register.

## Test plan
- ASIZE=6, standard: write 64 words 0..63 -> full=1, count=64, almost_full=1 (thresh 60); 65th write -> overflow=1, count stays 64; read all -> data 0..63 in order, each 1 cycle after read_enable, empty=1.
- Full, simultaneous read+write of 0xAA -> count stays 64, no overflow; 0xAA emerges as 64th subsequent read.
- Empty, read_enable with write_enable (0x55) -> underflow=1, count=1; next read returns 0x55.
- Wrap: 200 continuous write/read pairs with count held at 3 -> data order preserved across pointer MSB toggles, flags never glitch.
- FWFT=1: write 0x11,0x22 -> read_data=0x11, read_valid=1 with no read; pop -> 0x22; pop -> read_valid=0, empty=1.
- clear at count=10 with overflow set -> next cycle count=0, empty=1, overflow=0; rst pulse mid-burst -> all outputs at reset values before next edge.
